keysw_io_dev: RTL
=================

# keysw_io_dev

Memory-mapped responder for the board's push-buttons (KEY[3:0]) and slide switches (SW[9:0]) on the processor's data bus. It synchronizes the raw pins, optionally debounces them, and holds the stable values in data registers. It captures changes in sticky Ready/Overrun status bits and raises an interrupt request. It occupies the KEY/SW window of the I/O page alongside the HEX and LEDR devices, and supplies read data to the memory stage's bus multiplexer.

## Interface
Parameters:
- DBITS, 32, bus data/address width
- ADDRKEY, 32'hFFFFF080, KEY data register address; KEY control/status at ADDRKEY+4
- ADDRSW, 32'hFFFFF090, SW data register address; SW control/status at ADDRSW+4
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required before a data register updates (only with debounce enabled)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- addr  in  DBITS  bus byte address, full compare
- wrdata  in  DBITS  bus write data
- we  in  1  bus write strobe, sampled at posedge clk
- re  in  1  bus read strobe; read side effects occur at posedge clk
- rddata  out  DBITS  read data, combinational from addr; 0 when sel=0
- sel  out  1  combinational; 1 when addr matches one of the four registers
- key_n  in  4  raw KEY pins, active-low, asynchronous
- sw  in  10  raw SW pins, asynchronous
- irq  out  1  registered interrupt request

## Operation
- Input path per device: 2-flop synchronizer (KEY inverted to active-high first), then stabilizer, then data register (KDATA[3:0], SDATA[9:0]).
- Register map:
  - ADDRKEY: KDATA, zero-extended; read-only.
  - ADDRKEY+4: KCTRL.
  - ADDRSW: SDATA, zero-extended; read-only.
  - ADDRSW+4: SCTRL.
  - Writes to data registers are ignored.
- CTRL layout:
  - bit0 Ready: set when the data register changes value.
  - bit2 Overrun: set when a change occurs while Ready=1.
  - bit8 IE: read/write.
  - All other bits read 0.
- CTRL write behaviour:
  - Ready and Overrun: writing 0 clears the bit; writing 1 has no effect.
  - IE takes wrdata[8].
- A read (re=1) of a data register clears that device's Ready at the clock edge.
- Simultaneous events, same edge:
  - Change plus data-register read: Ready stays 1; Overrun is unchanged.
  - Change plus CTRL write of Ready=0: Ready=1 (set wins); Overrun is set only if Ready was 1 before the edge.
  - Data read and CTRL write together cannot occur (single address).
- we and re both asserted: the write is performed. A read side effect applies only if addr is a data register.
- irq <= (KCTRL.IE & KCTRL.Ready) | (SCTRL.IE & SCTRL.Ready), registered.
- Reset (asynchronous, any time including mid-debounce): synchronizers, data registers, counters, CTRL, and irq all go to 0. Pins held pressed at release of reset produce a change, with Ready set after the normal latency.

## Timing
- Read data is valid in the same cycle addr is presented; there are no wait states.
- Pin-to-data latency:
  - Debounce disabled: 3 edges (2 synchronizer edges + 1 data register edge).
  - Debounce enabled: 2 + DEBOUNCE_CYCLES edges.
- Stabilizer counter, one per device, width clog2(DEBOUNCE_CYCLES)+1:
  - Reset to 0 whenever the synchronized value equals the data register, or differs from the previous cycle's synchronized value.
  - Otherwise increments.
  - When the count reaches DEBOUNCE_CYCLES-1 with a difference present, the data register loads the synchronized value and the counter clears.
  - The counter saturates and never wraps.
- Ready/Overrun update on the same edge as the data register. irq asserts on the following edge.
- A glitch shorter than DEBOUNCE_CYCLES never reaches the data register.

## Configuration
- KEYSW_DEBOUNCE_EN defined: stabilizer counters instantiated per device; latency as above.
- KEYSW_DEBOUNCE_EN undefined: no counters, DEBOUNCE_CYCLES ignored; the data register loads the synchronized value every cycle (3-edge latency). All register and status semantics are otherwise identical.

## Test plan
- Reset asserted mid-cycle → all four registers read 0, irq=0, sel=0 for addr 32'h00001000 with rddata=0.
- Debounce enabled, DEBOUNCE_CYCLES=4, key_n 4'hF→4'hE held → KDATA reads 1 exactly 6 edges later, KCTRL reads 32'h1; a 3-cycle pulse on sw[0] leaves SDATA=0.
- Two key changes with no read → KCTRL=32'h5. Write KCTRL=32'h100 → KCTRL=32'h100, IE set, Ready/Overrun cleared.
- SCTRL IE=1, sw→10'h3FF → irq=1 one edge after Ready sets; read ADDRSW → returns 32'h3FF, Ready=0, irq=0 the next edge after that.
- Change lands on the same edge as a KDATA read → Ready remains 1, Overrun remains 0.
- Debounce disabled: sw 0→10'h155 → SDATA=32'h155 after 3 edges; write to ADDRSW ignored.

Source files
------------

// File: rtl/keysw_io_dev.sv
// KEY/SW memory-mapped input device: synchronize, optionally debounce, sticky Ready/Overrun, irq.
// Optional stabilizer counters are built when KEYSW_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module keysw_io_dev #(
  parameter int                 DBITS           = 32,
  parameter logic [DBITS-1:0]   ADDRKEY         = 32'hFFFFF080,
  parameter logic [DBITS-1:0]   ADDRSW          = 32'hFFFFF090,
  parameter int                 DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wrdata,
  input  logic             we,
  input  logic             re,
  output logic [DBITS-1:0] rddata,
  output logic             sel,
  input  logic [3:0]       key_n,
  input  logic [9:0]       sw,
  output logic             irq
);

  localparam logic [DBITS-1:0] KCTRL_ADDR = ADDRKEY + DBITS'(4);
  localparam logic [DBITS-1:0] SCTRL_ADDR = ADDRSW + DBITS'(4);

  logic [3:0] key_s1, key_s2, kdata;
  logic [9:0] sw_s1, sw_s2, sdata;
  logic       kchg, schg;
  logic [2:0] kst, sst;   // {ie, overrun, ready}

  // Next status from current status, data change, data read and ctrl write.
  function automatic logic [2:0] status_next(input logic [2:0] cur, input logic chg,
                                             input logic rd, input logic wr,
                                             input logic [DBITS-1:0] d);
    logic rdy, ovr, ie;
    rdy = cur[0];
    ovr = cur[1];
    ie  = cur[2];
    if (wr) begin
      if (!d[0]) rdy = 1'b0;
      if (!d[2]) ovr = 1'b0;
      ie = d[8];
    end
    if (rd) rdy = 1'b0;
    if (chg) begin
      ovr = ovr | (cur[0] & ~rd);
      rdy = 1'b1;
    end
    return {ie, ovr, rdy};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= ~key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

`ifdef KEYSW_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [CW-1:0] kcnt, scnt;

  // s1 != s2 means a newer pin value is still in flight, so stability restarts.
  assign kchg = (key_s2 != kdata) && (key_s1 == key_s2) && (kcnt == CW'(DEBOUNCE_CYCLES - 1));
  assign schg = (sw_s2 != sdata) && (sw_s1 == sw_s2) && (scnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kcnt <= '0;
      scnt <= '0;
    end else begin
      if (key_s2 == kdata || key_s1 != key_s2 || kchg) kcnt <= '0;
      else if (kcnt != '1)                            kcnt <= kcnt + 1'b1;
      if (sw_s2 == sdata || sw_s1 != sw_s2 || schg)   scnt <= '0;
      else if (scnt != '1)                            scnt <= scnt + 1'b1;
    end
  end
`else
  assign kchg = (key_s2 != kdata);
  assign schg = (sw_s2 != sdata);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kdata <= '0;
      sdata <= '0;
      kst   <= '0;
      sst   <= '0;
      irq   <= 1'b0;
    end else begin
      if (kchg) kdata <= key_s2;
      if (schg) sdata <= sw_s2;
      kst <= status_next(kst, kchg, re && (addr == ADDRKEY), we && (addr == KCTRL_ADDR), wrdata);
      sst <= status_next(sst, schg, re && (addr == ADDRSW),  we && (addr == SCTRL_ADDR), wrdata);
      irq <= (kst[2] & kst[0]) | (sst[2] & sst[0]);
    end
  end

  always_comb begin
    sel    = 1'b0;
    rddata = '0;
    if (addr == ADDRKEY) begin
      sel    = 1'b1;
      rddata = DBITS'(kdata);
    end else if (addr == KCTRL_ADDR) begin
      sel    = 1'b1;
      rddata = DBITS'({kst[2], 5'b0, kst[1], 1'b0, kst[0]});
    end else if (addr == ADDRSW) begin
      sel    = 1'b1;
      rddata = DBITS'(sdata);
    end else if (addr == SCTRL_ADDR) begin
      sel    = 1'b1;
      rddata = DBITS'({sst[2], 5'b0, sst[1], 1'b0, sst[0]});
    end
  end

endmodule
